// File: rtl/msi_pkg.sv
// Shared bus-protocol definitions for the MSI cache controllers and the memory
// bus responder: bus message encoding, responder FSM state type and the width
// of the memory wait counter.
package msi_pkg;

  // Bus message encoding, common to the CPU-side and snoop-side controllers
  localparam logic [1:0] OP_NONE       = 2'b00;
  localparam logic [1:0] OP_READ_MISS  = 2'b01;
  localparam logic [1:0] OP_WRITE_MISS = 2'b10;
  localparam logic [1:0] OP_INVALIDATE = 2'b11;

  // Wide enough for the largest legal memory latency (15)
  localparam int unsigned CNT_W = 4;

  typedef enum logic [2:0] {
    StIdle,
    StSnoop,
    StWriteback,
    StMemWait,
    StRespond
  } resp_state_e;

endpackage

// File: rtl/mem_block_array.sv
// Block storage behind the bus responder.
// Ports:
//   clk    - clock, write on rising edge
//   we     - write enable
//   waddr  - write block address
//   wdata  - write block data
//   raddr  - read block address
//   rdata  - read block data (combinational read)
// Contents are not reset; they start at zero in simulation.
module mem_block_array #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [Depth] = '{default: '0};

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mem_bus_responder.sv
// Memory-side responder for an MSI snooping bus. Accepts one bus request at a
// time, gives snooping caches one cycle to write back or supply the block,
// then answers from the cache data or from memory after MEM_LATENCY cycles.
// Ports:
//   clk, reset         - clock and synchronous active-high reset
//   bus_req_valid      - request present on the bus
//   bus_op, bus_addr   - bus message and block address
//   write_back_block   - snooper holds the block Modified, write it back
//   abort_mem_access   - snooper supplies the block, skip the memory read
//   wb_data            - block data from the snooper
//   bus_ready          - responder idle, request can be accepted
//   resp_valid         - one-cycle response strobe
//   resp_op, resp_data - answered message and block data
// Optional: define MEM_BUS_RESPONDER_STATS_EN for saturating activity counters
//   stat_mem_reads, stat_writebacks, stat_aborts.
module mem_bus_responder
  import msi_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned MEM_LATENCY = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bus_req_valid,
  input  logic [1:0]        bus_op,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic              write_back_block,
  input  logic              abort_mem_access,
  input  logic [DATA_W-1:0] wb_data,
  output logic              bus_ready,
  output logic              resp_valid,
  output logic [1:0]        resp_op,
`ifdef MEM_BUS_RESPONDER_STATS_EN
  output logic [15:0]       stat_mem_reads,
  output logic [15:0]       stat_writebacks,
  output logic [15:0]       stat_aborts,
`endif
  output logic [DATA_W-1:0] resp_data
);

  localparam logic [CNT_W-1:0] CntLoad = CNT_W'(MEM_LATENCY - 1);

  resp_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [1:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic              abort_q;
  logic [DATA_W-1:0] data_q;
  logic              resp_valid_q;
  logic [1:0]        resp_op_q;
  logic [DATA_W-1:0] resp_data_q;
  logic [DATA_W-1:0] rd_data;
  logic              accept;
  logic              mem_we;

  assign accept    = (state_q == StIdle) && bus_req_valid && (bus_op != OP_NONE);
  assign bus_ready = (state_q == StIdle);
  // A write coinciding with a reset edge is dropped
  assign mem_we    = (state_q == StWriteback) && !reset;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:      if (accept) state_d = StSnoop;
      StSnoop: begin
        if (write_back_block)            state_d = StWriteback;
        else if (abort_mem_access)       state_d = StRespond;
        else if (op_q == OP_INVALIDATE)  state_d = StRespond;
        else                             state_d = StMemWait;
      end
      StWriteback: begin
        if (abort_q || (op_q == OP_INVALIDATE)) state_d = StRespond;
        else                                    state_d = StMemWait;
      end
      StMemWait:   if (cnt_q == '0) state_d = StRespond;
      StRespond:   state_d = StIdle;
      default:     state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      op_q         <= OP_NONE;
      addr_q       <= '0;
      abort_q      <= 1'b0;
      data_q       <= '0;
      resp_valid_q <= 1'b0;
      resp_op_q    <= OP_NONE;
      resp_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      resp_valid_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (accept) begin
            op_q   <= bus_op;
            addr_q <= bus_addr;
          end
        end
        StSnoop: begin
          abort_q <= abort_mem_access;
          // Plain invalidate answers with zero; every other path keeps the
          // snooper's block (overwritten later if memory is read)
          if (!write_back_block && !abort_mem_access && (op_q == OP_INVALIDATE)) begin
            data_q <= '0;
          end else begin
            data_q <= wb_data;
          end
        end
        StMemWait: begin
          if (cnt_q == '0) data_q <= rd_data;
        end
        StRespond: begin
          resp_valid_q <= 1'b1;
          resp_op_q    <= op_q;
          resp_data_q  <= data_q;
        end
        default: ;
      endcase
      if ((state_d == StMemWait) && (state_q != StMemWait)) begin
        cnt_q <= CntLoad;
      end else if ((state_q == StMemWait) && (cnt_q != '0)) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_op    = resp_op_q;
  assign resp_data  = resp_data_q;

  mem_block_array #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_mem (
    .clk  (clk),
    .we   (mem_we),
    .waddr(addr_q),
    .wdata(data_q),
    .raddr(addr_q),
    .rdata(rd_data)
  );

`ifdef MEM_BUS_RESPONDER_STATS_EN
  logic enter_mem_wait, enter_writeback, enter_abort;

  assign enter_mem_wait  = (state_d == StMemWait) && (state_q != StMemWait);
  assign enter_writeback = (state_d == StWriteback) && (state_q != StWriteback);
  // Responses supplied by a snooping cache rather than memory
  assign enter_abort     = (state_d == StRespond) &&
                           (((state_q == StSnoop) && !write_back_block && abort_mem_access) ||
                            ((state_q == StWriteback) && abort_q));

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_mem_reads  <= '0;
      stat_writebacks <= '0;
      stat_aborts     <= '0;
    end else begin
      if (enter_mem_wait && (stat_mem_reads != 16'hFFFF))   stat_mem_reads  <= stat_mem_reads + 1'b1;
      if (enter_writeback && (stat_writebacks != 16'hFFFF)) stat_writebacks <= stat_writebacks + 1'b1;
      if (enter_abort && (stat_aborts != 16'hFFFF))         stat_aborts     <= stat_aborts + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed bench for mem_bus_responder (DATA_W=8, ADDR_W=4, MEM_LATENCY=3):
// a table of single transactions plus hand sequences for overlapping requests
// and reset in the middle of a transaction.
module tb_mem_bus_responder;

  logic       clk = 1'b0;
  logic       reset;
  logic       bus_req_valid;
  logic [1:0] bus_op;
  logic [3:0] bus_addr;
  logic       write_back_block;
  logic       abort_mem_access;
  logic [7:0] wb_data;
  logic       bus_ready;
  logic       resp_valid;
  logic [1:0] resp_op;
  logic [7:0] resp_data;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_bus_responder #(
    .DATA_W(8),
    .ADDR_W(4),
    .MEM_LATENCY(3)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .bus_req_valid   (bus_req_valid),
    .bus_op          (bus_op),
    .bus_addr        (bus_addr),
    .write_back_block(write_back_block),
    .abort_mem_access(abort_mem_access),
    .wb_data         (wb_data),
    .bus_ready       (bus_ready),
    .resp_valid      (resp_valid),
    .resp_op         (resp_op),
    .resp_data       (resp_data)
  );

  typedef struct {
    logic [1:0] op;
    logic [3:0] addr;
    logic       wb;
    logic       ab;
    logic [7:0] wbd;
    int         lat;
    logic [7:0] data;
  } vec_t;

  localparam int NVec = 13;
  vec_t vecs[NVec];

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // One request with snoop responses during the SNOOP cycle; measures edges
  // from the accepting edge until resp_valid is seen.
  task automatic do_txn(input vec_t v, input int idx);
    int lat;
    bit got;
    @(negedge clk);
    check($sformatf("v%0d bus_ready before", idx), bus_ready, 1);
    bus_req_valid = 1'b1;
    bus_op        = v.op;
    bus_addr      = v.addr;
    @(posedge clk);
    #1;
    bus_req_valid    = 1'b0;
    bus_op           = 2'b00;
    write_back_block = v.wb;
    abort_mem_access = v.ab;
    wb_data          = v.wbd;
    check($sformatf("v%0d bus_ready busy", idx), bus_ready, 0);
    lat = 0;
    got = 0;
    while (!got && lat < 30) begin
      @(posedge clk);
      lat++;
      #1;
      if (lat == 1) begin
        write_back_block = 1'b0;
        abort_mem_access = 1'b0;
        wb_data          = 8'h00;
      end
      if (resp_valid) got = 1;
    end
    check($sformatf("v%0d latency", idx), lat, v.lat);
    check($sformatf("v%0d resp_op", idx), resp_op, v.op);
    check($sformatf("v%0d resp_data", idx), resp_data, v.data);
    @(posedge clk);
    #1;
    check($sformatf("v%0d resp_valid pulse", idx), resp_valid, 0);
  endtask

  initial begin
    int lat;
    bit got;
    int extra;
    vec_t rd5;

    //          op     addr  wb    ab    wbd    lat data
    vecs[0]  = '{2'b10, 4'd5, 1'b1, 1'b1, 8'hA5, 3, 8'hA5}; // preload mem[5]
    vecs[1]  = '{2'b01, 4'd5, 1'b0, 1'b0, 8'h00, 5, 8'hA5}; // memory read
    vecs[2]  = '{2'b01, 4'd2, 1'b1, 1'b1, 8'h3C, 3, 8'h3C}; // writeback + supply
    vecs[3]  = '{2'b01, 4'd2, 1'b0, 1'b0, 8'h00, 5, 8'h3C}; // reads written block
    vecs[4]  = '{2'b11, 4'd7, 1'b0, 1'b0, 8'h00, 2, 8'h00}; // plain invalidate
    vecs[5]  = '{2'b10, 4'd1, 1'b1, 1'b0, 8'h11, 6, 8'h11}; // writeback + mem read
    vecs[6]  = '{2'b01, 4'd1, 1'b0, 1'b0, 8'h00, 5, 8'h11};
    vecs[7]  = '{2'b01, 4'd3, 1'b0, 1'b1, 8'h77, 2, 8'h77}; // supply, no write
    vecs[8]  = '{2'b01, 4'd3, 1'b0, 1'b0, 8'h00, 5, 8'h00};
    vecs[9]  = '{2'b11, 4'd4, 1'b1, 1'b0, 8'h4E, 3, 8'h4E}; // invalidate w/ writeback
    vecs[10] = '{2'b01, 4'd4, 1'b0, 1'b0, 8'h00, 5, 8'h4E};
    vecs[11] = '{2'b10, 4'd6, 1'b0, 1'b0, 8'h00, 5, 8'h00};
    vecs[12] = '{2'b11, 4'd5, 1'b0, 1'b1, 8'h99, 2, 8'h99}; // abort beats invalidate
    rd5      = '{2'b01, 4'd5, 1'b0, 1'b0, 8'h00, 5, 8'hA5};

    reset            = 1'b1;
    bus_req_valid    = 1'b0;
    bus_op           = 2'b00;
    bus_addr         = 4'd0;
    write_back_block = 1'b0;
    abort_mem_access = 1'b0;
    wb_data          = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("reset bus_ready", bus_ready, 1);
    check("reset resp_valid", resp_valid, 0);
    check("reset resp_op", resp_op, 0);
    check("reset resp_data", resp_data, 0);
    reset = 1'b0;

    // NONE requests are not accepted
    @(negedge clk);
    bus_req_valid = 1'b1;
    bus_op        = 2'b00;
    bus_addr      = 4'd5;
    @(posedge clk);
    #1;
    bus_req_valid = 1'b0;
    check("op NONE ignored", bus_ready, 1);

    for (int i = 0; i < NVec; i++) do_txn(vecs[i], i);

    // Request held on the bus after acceptance must be ignored
    @(negedge clk);
    bus_req_valid = 1'b1;
    bus_op        = 2'b11;
    bus_addr      = 4'd7;
    @(posedge clk);
    #1;
    bus_op   = 2'b01;
    bus_addr = 4'd5;
    lat = 0;
    got = 0;
    while (!got && lat < 30) begin
      @(posedge clk);
      lat++;
      #1;
      bus_req_valid = 1'b0;
      bus_op        = 2'b00;
      if (resp_valid) got = 1;
    end
    check("overlap latency", lat, 2);
    check("overlap resp_op", resp_op, 2'b11);
    check("overlap resp_data", resp_data, 0);
    extra = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (resp_valid) extra++;
    end
    check("overlap no second resp", extra, 0);
    check("overlap idle", bus_ready, 1);

    // Reset during MEM_WAIT abandons the read
    @(negedge clk);
    bus_req_valid = 1'b1;
    bus_op        = 2'b01;
    bus_addr      = 4'd5;
    @(posedge clk);
    #1;
    bus_req_valid = 1'b0;
    bus_op        = 2'b00;
    @(posedge clk);  // SNOOP -> MEM_WAIT
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("memwait reset bus_ready", bus_ready, 1);
    check("memwait reset resp_valid", resp_valid, 0);
    check("memwait reset resp_op", resp_op, 0);
    check("memwait reset resp_data", resp_data, 0);
    extra = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (resp_valid) extra++;
    end
    check("memwait reset no resp", extra, 0);
    do_txn(rd5, 100);

    // Reset on the WRITEBACK cycle must not commit the write
    @(negedge clk);
    bus_req_valid = 1'b1;
    bus_op        = 2'b01;
    bus_addr      = 4'd8;
    @(posedge clk);
    #1;
    bus_req_valid    = 1'b0;
    bus_op           = 2'b00;
    write_back_block = 1'b1;
    wb_data          = 8'hEE;
    @(posedge clk);  // SNOOP -> WRITEBACK
    #1;
    write_back_block = 1'b0;
    wb_data          = 8'h00;
    reset            = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("wb reset bus_ready", bus_ready, 1);
    do_txn('{2'b01, 4'd8, 1'b0, 1'b0, 8'h00, 5, 8'h00}, 101);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_bus_responder.md
MEM_BUS_RESPONDER -- requirements
Module: mem_bus_responder

Interface
REQ-001 Parameter DATA_W, default 8: width of one cache block, in bits.
REQ-002 Parameter ADDR_W, default 4: block address width; memory depth is 2**ADDR_W.
REQ-003 Parameter MEM_LATENCY, default 3, legal range 1..15: memory read wait, in cycles.
REQ-004 Port clk  in  1: single clock; all logic on the rising edge.
REQ-005 Port reset  in  1: synchronous, active-high reset.
REQ-006 Port bus_req_valid  in  1: a cache is placing a request on the bus.
REQ-007 Port bus_op  in  2: bus message, encoded NONE=00, READ_MISS=01, WRITE_MISS=10, INVALIDATE=11.
REQ-008 Port bus_addr  in  ADDR_W: block address of the request.
REQ-009 Port write_back_block  in  1: a snooping cache holds the block Modified and must write it back.
REQ-010 Port abort_mem_access  in  1: a snooping cache supplies the block, so the memory read is cancelled.
REQ-011 Port wb_data  in  DATA_W: block data from the snooping cache.
REQ-012 Port bus_ready  out  1: responder is idle and can accept a request.
REQ-013 Port resp_valid  out  1: one-cycle response strobe.
REQ-014 Port resp_op  out  2: echo of the bus_op being answered.
REQ-015 Port resp_data  out  DATA_W: data for the block being answered.

Function
REQ-016 The FSM SHALL have exactly the states IDLE, SNOOP, WRITEBACK, MEM_WAIT and RESPOND.
REQ-017 In IDLE, bus_ready SHALL be 1; in every other state it SHALL be 0.
REQ-018 In IDLE, a request with bus_req_valid=1 and bus_op≠NONE SHALL be accepted: op and address are latched and the FSM moves to SNOOP.
REQ-019 Requests with bus_op=NONE, and any requests arriving outside IDLE, SHALL be ignored.
REQ-020 SNOOP SHALL last exactly one cycle and sample write_back_block, abort_mem_access and wb_data, with wb_data latched.
REQ-021 SNOOP priority:
- write_back_block=1 → WRITEBACK;
- else abort_mem_access=1 → RESPOND, resp_data = latched wb_data;
- else INVALIDATE → RESPOND, resp_data = 0;
- else → MEM_WAIT.
REQ-022 WRITEBACK SHALL write the latched wb_data to mem[addr] in one cycle. Next state: RESPOND with wb_data if abort was sampled or op is INVALIDATE; otherwise MEM_WAIT.
REQ-023 MEM_WAIT SHALL load a counter with MEM_LATENCY-1 on entry and decrement it each cycle. At 0, mem[addr] is captured into resp_data and the FSM moves to RESPOND.
REQ-024 RESPOND SHALL assert resp_valid for exactly one cycle, present resp_op and resp_data, then return to IDLE.
REQ-025 Outside RESPOND, resp_valid SHALL be 0; resp_op and resp_data hold their last values.
REQ-026 Latency from the accepting edge to resp_valid SHALL be:
- memory read: MEM_LATENCY+2 cycles;
- cache-supplied or invalidate: 2 cycles;
- writeback followed by cache supply: 3 cycles;
- writeback followed by memory read: MEM_LATENCY+3 cycles.
REQ-027 A WRITE_MISS SHALL be handled identically to a READ_MISS (write-allocate); the responder never writes requester data.

Reset
REQ-028 While reset=1 at a clock edge, the FSM SHALL go to IDLE, the counter SHALL clear, and resp_valid, resp_op and resp_data SHALL all become 0.
REQ-029 Reset asserted mid-transaction SHALL abandon it with no response. A write in progress at that edge SHALL NOT commit.
REQ-030 Memory contents SHALL NOT be affected by reset; simulation initial contents are all zero.

Configuration
REQ-031 Macro MEM_BUS_RESPONDER_STATS_EN, when defined, SHALL add 16-bit saturating output counters:
- stat_mem_reads (MEM_WAIT entries);
- stat_writebacks (WRITEBACK entries);
- stat_aborts (cache-supplied responses).
All three are cleared by reset. When the macro is undefined, these ports and their logic SHALL be absent.

Structure
REQ-032 Package msi_pkg SHALL hold the bus_op encoding constants and the FSM state typedef. The CPU-side and snoop-side controllers SHALL share these constants.
REQ-033 Sub-module mem_block_array SHALL provide one synchronous write port and one read port; the FSM SHALL instantiate it.

Verification (MEM_LATENCY=3, DATA_W=8)
REQ-034 Preload mem[5]=0xA5; READ_MISS addr 5, no snoop signals → resp_valid 5 cycles after accept, resp_data=0xA5, resp_op=01.
REQ-035 READ_MISS addr 2, write_back_block=1, abort_mem_access=1, wb_data=0x3C in SNOOP → resp_data=0x3C at 3 cycles; a later READ_MISS addr 2 with no snoop returns 0x3C.
REQ-036 INVALIDATE addr 7 → resp_valid at 2 cycles, resp_data=0, no memory access; a second request on the same edge as the first accept is ignored.
REQ-037 WRITE_MISS addr 1 with write_back_block=1 only, wb_data=0x11 → mem[1]=0x11; resp_data=0x11 at 6 cycles.
REQ-038 Reset asserted during MEM_WAIT → next cycle state is IDLE and bus_ready=1; no resp_valid; memory unchanged.
